if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the five-stage MIPS core.
- Owns the PC and drives the synchronous inst_rom (iaddr/ice).
- Selects the next PC from the decode stage's jump targets (jtsel, jump_addr_1/2/3) or from the CP0 exception vector on flush.
- Registers id_pc_i, pc_plus_4 and id_in_delay_i, and produces flush_im for the decode stage.

Parameters:
PC_INIT, 32'h0000_0000, reset/start PC (shared constant `PC_INIT)
ADDR_W, 32, instruction address width (`INST_ADDR_BUS)

Ports:
cpu_clk_50M  in  1  system clock, rising edge
cpu_rst_n  in  1  asynchronous active-low reset
stall  in  2  [0] hold PC, [1] hold IF/ID register (from stall controller)
flush  in  1  exception/eret flush from CP0/MEM
cp0_excaddr  in  32  PC to fetch after flush
jtsel  in  2  jump-target select from decode
jump_addr_1  in  32  J/JAL target
jump_addr_2  in  32  BEQ/BNE target
jump_addr_3  in  32  JR target
next_delay_i  in  1  decode's "next instruction is in a delay slot"
ice  out  1  inst_rom chip enable
iaddr  out  32  inst_rom address (= pc)
pc  out  32  current fetch PC
id_pc_o  out  32  registered PC to decode
id_pc_plus_4_o  out  32  registered PC+4 to decode
id_in_delay_o  out  1  registered delay-slot flag to decode
flush_im  out  1  kill flag for the instruction now arriving from inst_rom

Behaviour:
Reset (cpu_rst_n=0, asynchronous):
- ce=0, pc=PC_INIT, id_pc_o=PC_INIT, id_pc_plus_4_o=PC_INIT+4, id_in_delay_o=0, flush_im=1.
- ice is combinationally 0 while ce=0.

Start-up:
- First edge after reset release: ce<=1, pc stays PC_INIT.
- PC advances from the second edge onward. PC_INIT is fetched exactly once.

Next-PC priority, evaluated each edge with ce=1:
1. flush=1 -> pc<=cp0_excaddr, regardless of stall or jtsel.
2. stall[0]=1 -> pc holds.
3. jtsel selects the next PC:
   - 00 -> pc+4
   - 01 -> jump_addr_1
   - 10 -> jump_addr_3
   - 11 -> jump_addr_2

Arithmetic:
- pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- No alignment check; target low bits pass through unchanged.

Combinational outputs:
- iaddr=pc; ice=ce.
- While stalled the ROM re-reads the same address, so a held IF/ID sees a consistent instruction.

IF/ID register, each edge:
1. flush=1 -> id_pc_o<=PC_INIT, id_pc_plus_4_o<=PC_INIT+4, id_in_delay_o<=0, flush_im<=1.
2. Else if stall[1]=1 -> all hold, including flush_im.
3. Else -> id_pc_o<=pc, id_pc_plus_4_o<=pc+4, id_in_delay_o<=next_delay_i, flush_im<=0.

Stall encoding:
- stall=2'b10 is illegal. It is treated as 2'b11 (PC also holds); assertion in bench.
- stall=2'b01 holds the PC only. IF/ID still captures, so the same PC is delivered twice. The controller never issues it; this is a defined but unused case.

Latency:
- Branch resolved in ID redirects the PC at the next edge.
- The delay-slot instruction, already in IF, proceeds normally.
- id_in_delay_o=1 marks that delay-slot instruction when it reaches ID.

Reset mid-operation aborts any state immediately; the start-up sequence repeats.

Decomposition:
- Shared define package: `PC_INIT, `INST_ADDR_BUS, `JTSEL_BUS, `STOP/`NOSTOP, `FLUSH, `RST_ENABLE, and jtsel codes (`JT_SEQ=00, `JT_J=01, `JT_JR=10, `JT_BR=11).
- One sub-module: ifid_reg, holding the IF/ID register with flush/stall priority.
- PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset release, jtsel=00, no stall:
  - iaddr is 0x0 for two cycles, then 0x4, 0x8.
  - ice rises one cycle after reset release.
  - id_pc_o lags iaddr by one cycle.
  - flush_im is 1 until the first capture, then 0.
- pc=0x100, jtsel=11, jump_addr_2=0x200 for one cycle:
  - Next iaddr=0x200.
  - With next_delay_i=1 on that cycle, id_pc_o=0x104 with id_in_delay_o=1, then id_pc_o=0x200 with id_in_delay_o=0.
- stall=2'b11 for 2 cycles at pc=0x40:
  - iaddr, id_pc_o and id_in_delay_o are all frozen.
  - Release -> 0x44 follows.
- flush=1 with cp0_excaddr=0x0000_0180, stall=2'b11, jtsel=01 simultaneously:
  - Next pc=0x180.
  - IF/ID cleared to PC_INIT.
  - flush_im=1 for exactly one cycle.
- jtsel=01 (jump_addr_1=0x1000) and jtsel=10 (jump_addr_3=0x2004):
  - Each redirects the PC at the next edge.
- Wrap and async reset:
  - Force pc=0xFFFF_FFFC -> next pc=0x0.
  - Assert cpu_rst_n=0 mid-cycle -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage of the five-stage MIPS core.
package if_stage_pkg;

   localparam int                 INST_ADDR_BUS = 32;
   localparam int                 JTSEL_BUS     = 2;
   localparam logic [31:0]        PC_INIT       = 32'h0000_0000;

   localparam logic               STOP          = 1'b1;
   localparam logic               NOSTOP        = 1'b0;
   localparam logic               FLUSH         = 1'b1;
   localparam logic               RST_ENABLE    = 1'b0;

   // Jump-target select codes produced by the decode stage.
   typedef enum logic [JTSEL_BUS-1:0] {
      JT_SEQ = 2'b00,
      JT_J   = 2'b01,
      JT_JR  = 2'b10,
      JT_BR  = 2'b11
   } jtsel_e;

   // Sequential successor of an instruction address; wraps modulo 2^32.
   function automatic logic [INST_ADDR_BUS-1:0] pc_inc(input logic [INST_ADDR_BUS-1:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control inputs, decode-side jump targets,
// inst_rom address bus and the IF/ID register outputs.
//
// Flow control: there is no valid/ready pair on this bundle. stall[0]
// freezes the PC, stall[1] freezes the IF/ID register, and flush overrides
// both. ice marks every cycle in which the inst_rom must read iaddr.
interface if_stage_if;
   import if_stage_pkg::*;

   logic [1:0]                stall;
   logic                      flush;
   logic [INST_ADDR_BUS-1:0]  cp0_excaddr;
   logic [JTSEL_BUS-1:0]      jtsel;
   logic [INST_ADDR_BUS-1:0]  jump_addr_1;
   logic [INST_ADDR_BUS-1:0]  jump_addr_2;
   logic [INST_ADDR_BUS-1:0]  jump_addr_3;
   logic                      next_delay_i;

   logic                      ice;
   logic [INST_ADDR_BUS-1:0]  iaddr;
   logic [INST_ADDR_BUS-1:0]  pc;
   logic [INST_ADDR_BUS-1:0]  id_pc_o;
   logic [INST_ADDR_BUS-1:0]  id_pc_plus_4_o;
   logic                      id_in_delay_o;
   logic                      flush_im;

   // Fetch-stage side.
   modport master (
      input  stall, flush, cp0_excaddr, jtsel,
      input  jump_addr_1, jump_addr_2, jump_addr_3, next_delay_i,
      output ice, iaddr, pc, id_pc_o, id_pc_plus_4_o, id_in_delay_o, flush_im
   );

   // Surrounding pipeline side (decode, CP0, stall controller, inst_rom).
   modport slave (
      output stall, flush, cp0_excaddr, jtsel,
      output jump_addr_1, jump_addr_2, jump_addr_3, next_delay_i,
      input  ice, iaddr, pc, id_pc_o, id_pc_plus_4_o, id_in_delay_o, flush_im
   );

endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: carries the fetch PC, its successor and the
// delay-slot flag into decode. Flush beats stall; flush_im kills the
// instruction word that the synchronous inst_rom delivers alongside.
module ifid_reg
   import if_stage_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      hold,
   input  logic [INST_ADDR_BUS-1:0]  pc,
   input  logic                      next_delay,
   output logic [INST_ADDR_BUS-1:0]  id_pc,
   output logic [INST_ADDR_BUS-1:0]  id_pc_plus_4,
   output logic                      id_in_delay,
   output logic                      flush_im
);

   // Capture, hold or clear the IF/ID contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_pc        <= PC_INIT;
         id_pc_plus_4 <= pc_inc(PC_INIT);
         id_in_delay  <= 1'b0;
         flush_im     <= 1'b1;
      end else if (flush == FLUSH) begin
         id_pc        <= PC_INIT;
         id_pc_plus_4 <= pc_inc(PC_INIT);
         id_in_delay  <= 1'b0;
         flush_im     <= 1'b1;
      end else if (hold == STOP) begin
         id_pc        <= id_pc;
         id_pc_plus_4 <= id_pc_plus_4;
         id_in_delay  <= id_in_delay;
         flush_im     <= flush_im;
      end else begin
         id_pc        <= pc;
         id_pc_plus_4 <= pc_inc(pc);
         id_in_delay  <= next_delay;
         flush_im     <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous inst_rom and
// feeds the IF/ID register. The PC redirects on flush (CP0 vector) or on a
// jump target resolved in decode; the delay-slot instruction already in
// IF proceeds normally.
module if_stage
   import if_stage_pkg::*;
(
   input  logic          cpu_clk_50M,
   input  logic          cpu_rst_n,
   if_stage_if.master    bus
);

   logic                      ce;
   logic [INST_ADDR_BUS-1:0]  pc_q;
   logic [INST_ADDR_BUS-1:0]  target;
   logic                      pc_hold;

   // stall=2'b10 is illegal; it is folded into a full hold so the PC never
   // runs ahead of a frozen IF/ID register.
   assign pc_hold = (bus.stall[0] == STOP) || (bus.stall[1] == STOP);

   // Next-PC candidate chosen by the decode stage's jump select.
   always_comb begin
      target = pc_inc(pc_q);
      case (jtsel_e'(bus.jtsel))
         JT_SEQ:  target = pc_inc(pc_q);
         JT_J:    target = bus.jump_addr_1;
         JT_JR:   target = bus.jump_addr_3;
         JT_BR:   target = bus.jump_addr_2;
         default: target = pc_inc(pc_q);
      endcase
   end

   // Chip enable and PC: the first edge after reset only raises ce so that
   // PC_INIT is fetched exactly once before the PC starts advancing.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         ce   <= 1'b0;
         pc_q <= PC_INIT;
      end else if (!ce) begin
         ce   <= 1'b1;
         pc_q <= pc_q;
      end else if (bus.flush == FLUSH) begin
         pc_q <= bus.cp0_excaddr;
      end else if (pc_hold) begin
         pc_q <= pc_q;
      end else begin
         pc_q <= target;
      end
   end

   // While stalled the ROM keeps reading the same address, so a held
   // IF/ID register sees a consistent instruction word.
   assign bus.iaddr = pc_q;
   assign bus.pc    = pc_q;
   assign bus.ice   = ce;

   ifid_reg u_ifid_reg (
      .clk          (cpu_clk_50M),
      .rst_n        (cpu_rst_n),
      .flush        (bus.flush),
      .hold         (bus.stall[1]),
      .pc           (pc_q),
      .next_delay   (bus.next_delay_i),
      .id_pc        (bus.id_pc_o),
      .id_pc_plus_4 (bus.id_pc_plus_4_o),
      .id_in_delay  (bus.id_in_delay_o),
      .flush_im     (bus.flush_im)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for the instruction-fetch stage: directed scenarios followed by
// randomized traffic against a rule-level reference model.
module tb_if_stage;
   import if_stage_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   if_stage_if bus();

   if_stage dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .bus         (bus.master)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic        m_ce;
   logic [31:0] m_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_pc4;
   logic        m_dly;
   logic        m_fim;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall        = 2'b00;
      bus.flush        = 1'b0;
      bus.cp0_excaddr  = 32'h0;
      bus.jtsel        = 2'b00;
      bus.jump_addr_1  = 32'h0;
      bus.jump_addr_2  = 32'h0;
      bus.jump_addr_3  = 32'h0;
      bus.next_delay_i = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      total++; if (bus.ice !== 1'b0) begin bad++; $display("FAIL reset_ice got=%b exp=0", bus.ice); end
      total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr got=%h exp=0", bus.iaddr); end
      total++; if (bus.id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_id_pc got=%h exp=0", bus.id_pc_o); end
      total++; if (bus.id_pc_plus_4_o !== 32'h4) begin bad++; $display("FAIL reset_id_pc4 got=%h exp=4", bus.id_pc_plus_4_o); end
      total++; if (bus.id_in_delay_o !== 1'b0) begin bad++; $display("FAIL reset_dly got=%b exp=0", bus.id_in_delay_o); end
      total++; if (bus.flush_im !== 1'b1) begin bad++; $display("FAIL reset_flush_im got=%b exp=1", bus.flush_im); end
   endtask

   task automatic test_startup();
      rst_n = 1'b1;
      total++; if (bus.ice !== 1'b0) begin bad++; $display("FAIL start_ice0 got=%b exp=0", bus.ice); end
      tick();
      total++; if (bus.ice !== 1'b1) begin bad++; $display("FAIL start_ice1 got=%b exp=1", bus.ice); end
      total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL start_iaddr_c1 got=%h exp=0", bus.iaddr); end
      total++; if (bus.flush_im !== 1'b0) begin bad++; $display("FAIL start_flush_im got=%b exp=0", bus.flush_im); end
      total++; if (bus.id_pc_o !== 32'h0) begin bad++; $display("FAIL start_id_pc_c1 got=%h exp=0", bus.id_pc_o); end
      tick();
      total++; if (bus.iaddr !== 32'h4) begin bad++; $display("FAIL start_iaddr_c2 got=%h exp=4", bus.iaddr); end
      total++; if (bus.id_pc_o !== 32'h0) begin bad++; $display("FAIL start_id_pc_c2 got=%h exp=0", bus.id_pc_o); end
      tick();
      total++; if (bus.iaddr !== 32'h8) begin bad++; $display("FAIL start_iaddr_c3 got=%h exp=8", bus.iaddr); end
      total++; if (bus.id_pc_o !== 32'h4) begin bad++; $display("FAIL start_id_pc_c3 got=%h exp=4", bus.id_pc_o); end
      total++; if (bus.id_pc_plus_4_o !== 32'h8) begin bad++; $display("FAIL start_id_pc4_c3 got=%h exp=8", bus.id_pc_plus_4_o); end
   endtask

   // Branch at 0x100 sits in ID while its delay slot 0x104 is in IF.
   task automatic test_branch();
      bus.jtsel = 2'b01; bus.jump_addr_1 = 32'h100;
      tick();
      total++; if (bus.iaddr !== 32'h100) begin bad++; $display("FAIL br_setup got=%h exp=100", bus.iaddr); end
      bus.jtsel = 2'b00;
      tick();
      bus.jtsel = 2'b11; bus.jump_addr_2 = 32'h200; bus.next_delay_i = 1'b1;
      tick();
      total++; if (bus.iaddr !== 32'h200) begin bad++; $display("FAIL br_target got=%h exp=200", bus.iaddr); end
      total++; if (bus.id_pc_o !== 32'h104) begin bad++; $display("FAIL br_slot_pc got=%h exp=104", bus.id_pc_o); end
      total++; if (bus.id_in_delay_o !== 1'b1) begin bad++; $display("FAIL br_slot_dly got=%b exp=1", bus.id_in_delay_o); end
      bus.jtsel = 2'b00; bus.next_delay_i = 1'b0;
      tick();
      total++; if (bus.id_pc_o !== 32'h200) begin bad++; $display("FAIL br_after_pc got=%h exp=200", bus.id_pc_o); end
      total++; if (bus.id_in_delay_o !== 1'b0) begin bad++; $display("FAIL br_after_dly got=%b exp=0", bus.id_in_delay_o); end
      total++; if (bus.iaddr !== 32'h204) begin bad++; $display("FAIL br_after_iaddr got=%h exp=204", bus.iaddr); end
   endtask

   task automatic test_stall();
      bus.jtsel = 2'b01; bus.jump_addr_1 = 32'h40; bus.next_delay_i = 1'b1;
      tick();
      bus.jtsel = 2'b00; bus.next_delay_i = 1'b0;
      // id_pc_o now holds 0x204 with delay flag 1
      bus.stall = 2'b11;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (bus.iaddr !== 32'h40) begin bad++; $display("FAIL stall_iaddr c%0d got=%h exp=40", i, bus.iaddr); end
         total++; if (bus.id_pc_o !== 32'h204) begin bad++; $display("FAIL stall_id_pc c%0d got=%h exp=204", i, bus.id_pc_o); end
         total++; if (bus.id_in_delay_o !== 1'b1) begin bad++; $display("FAIL stall_dly c%0d got=%b exp=1", i, bus.id_in_delay_o); end
      end
      bus.stall = 2'b00;
      tick();
      total++; if (bus.iaddr !== 32'h44) begin bad++; $display("FAIL stall_rel_iaddr got=%h exp=44", bus.iaddr); end
      total++; if (bus.id_pc_o !== 32'h40) begin bad++; $display("FAIL stall_rel_id_pc got=%h exp=40", bus.id_pc_o); end
   endtask

   task automatic test_flush();
      bus.flush = 1'b1; bus.cp0_excaddr = 32'h180; bus.stall = 2'b11;
      bus.jtsel = 2'b01; bus.jump_addr_1 = 32'h9999_0000; bus.next_delay_i = 1'b1;
      tick();
      total++; if (bus.iaddr !== 32'h180) begin bad++; $display("FAIL flush_pc got=%h exp=180", bus.iaddr); end
      total++; if (bus.id_pc_o !== PC_INIT) begin bad++; $display("FAIL flush_id_pc got=%h exp=%h", bus.id_pc_o, PC_INIT); end
      total++; if (bus.id_pc_plus_4_o !== 32'h4) begin bad++; $display("FAIL flush_id_pc4 got=%h exp=4", bus.id_pc_plus_4_o); end
      total++; if (bus.id_in_delay_o !== 1'b0) begin bad++; $display("FAIL flush_dly got=%b exp=0", bus.id_in_delay_o); end
      total++; if (bus.flush_im !== 1'b1) begin bad++; $display("FAIL flush_im_set got=%b exp=1", bus.flush_im); end
      idle_inputs();
      tick();
      total++; if (bus.flush_im !== 1'b0) begin bad++; $display("FAIL flush_im_clr got=%b exp=0", bus.flush_im); end
      total++; if (bus.id_pc_o !== 32'h180) begin bad++; $display("FAIL flush_next_id got=%h exp=180", bus.id_pc_o); end
      total++; if (bus.iaddr !== 32'h184) begin bad++; $display("FAIL flush_next_pc got=%h exp=184", bus.iaddr); end
   endtask

   task automatic test_jumps();
      bus.jtsel = 2'b01; bus.jump_addr_1 = 32'h1000;
      tick();
      total++; if (bus.iaddr !== 32'h1000) begin bad++; $display("FAIL jump_j got=%h exp=1000", bus.iaddr); end
      bus.jtsel = 2'b10; bus.jump_addr_3 = 32'h2004;
      tick();
      total++; if (bus.iaddr !== 32'h2004) begin bad++; $display("FAIL jump_jr got=%h exp=2004", bus.iaddr); end
      bus.jtsel = 2'b11; bus.jump_addr_2 = 32'h3003;
      tick();
      total++; if (bus.iaddr !== 32'h3003) begin bad++; $display("FAIL jump_unaligned got=%h exp=3003", bus.iaddr); end
      bus.jtsel = 2'b00;
      tick();
   endtask

   // Illegal stall=2'b10 behaves as a full hold.
   task automatic test_illegal_stall();
      logic [31:0] pc_before;
      logic [31:0] id_before;
      pc_before = 32'h3007;
      id_before = 32'h3003;
      bus.stall = 2'b10;
      bus.jtsel = 2'b01; bus.jump_addr_1 = 32'h5000;
      tick();
      total++; if (bus.iaddr !== pc_before) begin bad++; $display("FAIL stall10_pc got=%h exp=%h", bus.iaddr, pc_before); end
      total++; if (bus.id_pc_o !== id_before) begin bad++; $display("FAIL stall10_id got=%h exp=%h", bus.id_pc_o, id_before); end
      bus.stall = 2'b01; bus.jtsel = 2'b00;
      tick();
      total++; if (bus.iaddr !== pc_before) begin bad++; $display("FAIL stall01_pc got=%h exp=%h", bus.iaddr, pc_before); end
      total++; if (bus.id_pc_o !== pc_before) begin bad++; $display("FAIL stall01_id got=%h exp=%h", bus.id_pc_o, pc_before); end
      bus.stall = 2'b00;
      tick();
   endtask

   task automatic test_wrap();
      bus.jtsel = 2'b01; bus.jump_addr_1 = 32'hFFFF_FFFC;
      tick();
      bus.jtsel = 2'b00;
      tick();
      total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", bus.iaddr); end
      total++; if (bus.id_pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_id_pc got=%h exp=fffffffc", bus.id_pc_o); end
      total++; if (bus.id_pc_plus_4_o !== 32'h0) begin bad++; $display("FAIL wrap_id_pc4 got=%h exp=0", bus.id_pc_plus_4_o); end
   endtask

   task automatic test_async_reset();
      bus.next_delay_i = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.ice !== 1'b0) begin bad++; $display("FAIL areset_ice got=%b exp=0", bus.ice); end
      total++; if (bus.iaddr !== PC_INIT) begin bad++; $display("FAIL areset_iaddr got=%h exp=%h", bus.iaddr, PC_INIT); end
      total++; if (bus.id_pc_o !== PC_INIT) begin bad++; $display("FAIL areset_id_pc got=%h exp=%h", bus.id_pc_o, PC_INIT); end
      total++; if (bus.id_pc_plus_4_o !== 32'h4) begin bad++; $display("FAIL areset_id_pc4 got=%h exp=4", bus.id_pc_plus_4_o); end
      total++; if (bus.id_in_delay_o !== 1'b0) begin bad++; $display("FAIL areset_dly got=%b exp=0", bus.id_in_delay_o); end
      total++; if (bus.flush_im !== 1'b1) begin bad++; $display("FAIL areset_flush_im got=%b exp=1", bus.flush_im); end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (bus.ice !== 1'b1) begin bad++; $display("FAIL areset_restart_ice got=%b exp=1", bus.ice); end
      total++; if (bus.iaddr !== PC_INIT) begin bad++; $display("FAIL areset_restart_pc got=%h exp=%h", bus.iaddr, PC_INIT); end
   endtask

   task automatic test_random();
      logic        n_ce;
      logic [31:0] n_pc;
      logic [31:0] seq_or_jump;
      int          r;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_ce = 1'b0; m_pc = PC_INIT; m_id_pc = PC_INIT; m_id_pc4 = PC_INIT + 32'd4;
      m_dly = 1'b0; m_fim = 1'b1;
      for (int cyc = 0; cyc < 500; cyc++) begin
         r = $urandom_range(0, 9);
         bus.stall        = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
         bus.flush        = ($urandom_range(0, 15) == 0);
         bus.cp0_excaddr  = ($urandom_range(0, 1) == 0) ? 32'h180 : $urandom;
         bus.jtsel        = 2'($urandom_range(0, 3));
         bus.jump_addr_1  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
         bus.jump_addr_2  = $urandom;
         bus.jump_addr_3  = $urandom;
         bus.next_delay_i = 1'($urandom_range(0, 1));

         // Where the program goes if nothing intervenes.
         if (bus.jtsel == 2'b00)      seq_or_jump = m_pc + 32'd4;
         else if (bus.jtsel == 2'b01) seq_or_jump = bus.jump_addr_1;
         else if (bus.jtsel == 2'b10) seq_or_jump = bus.jump_addr_3;
         else                         seq_or_jump = bus.jump_addr_2;

         n_ce = 1'b1;
         if (!m_ce)                   n_pc = m_pc;
         else if (bus.flush)          n_pc = bus.cp0_excaddr;
         else if (bus.stall != 2'b00) n_pc = m_pc;
         else                         n_pc = seq_or_jump;

         if (bus.flush) begin
            m_id_pc = PC_INIT; m_id_pc4 = PC_INIT + 32'd4; m_dly = 1'b0; m_fim = 1'b1;
         end else if (bus.stall[1]) begin
            m_id_pc = m_id_pc;
         end else begin
            m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_dly = bus.next_delay_i; m_fim = 1'b0;
         end
         m_ce = n_ce;
         m_pc = n_pc;

         tick();
         total++; if (bus.ice !== m_ce) begin bad++; $display("FAIL rnd_ice cyc=%0d got=%b exp=%b", cyc, bus.ice, m_ce); end
         total++; if (bus.iaddr !== m_pc) begin bad++; $display("FAIL rnd_iaddr cyc=%0d got=%h exp=%h", cyc, bus.iaddr, m_pc); end
         total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, bus.pc, m_pc); end
         total++; if (bus.id_pc_o !== m_id_pc) begin bad++; $display("FAIL rnd_id_pc cyc=%0d got=%h exp=%h", cyc, bus.id_pc_o, m_id_pc); end
         total++; if (bus.id_pc_plus_4_o !== m_id_pc4) begin bad++; $display("FAIL rnd_id_pc4 cyc=%0d got=%h exp=%h", cyc, bus.id_pc_plus_4_o, m_id_pc4); end
         total++; if (bus.id_in_delay_o !== m_dly) begin bad++; $display("FAIL rnd_dly cyc=%0d got=%b exp=%b", cyc, bus.id_in_delay_o, m_dly); end
         total++; if (bus.flush_im !== m_fim) begin bad++; $display("FAIL rnd_flush_im cyc=%0d got=%b exp=%b", cyc, bus.flush_im, m_fim); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_startup();
      test_branch();
      test_stall();
      test_flush();
      test_jumps();
      test_illegal_stall();
      test_wrap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
